// File: rtl/vigna_coproc_dispatch.sv
// Dispatches RV32 M-extension instructions to a coprocessor unit and writes the result back.
// Define VIGNA_COPROC_RESULT_CACHE_EN to add a single-entry result cache that skips the unit on a repeat.
module vigna_coproc_dispatch (
  input  logic        clk,
  input  logic        resetn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        cp_valid,
  input  logic        cp_ready,
  output logic [2:0]  cp_func,
  output logic [2:0]  cp_id,
  output logic [31:0] cp_op1,
  output logic [31:0] cp_op2,
  input  logic [31:0] cp_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic        illegal,
  input  logic        cache_flush
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  func_q, func_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] res_q, res_d;
  logic        illegal_q, illegal_d;

  logic        accept;
  logic        is_m;
  logic        hit;
  logic [31:0] hit_res;
  logic        unused_instr;

  assign accept       = issue_valid && issue_ready;
  assign is_m         = (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001);
  assign unused_instr = ^instr[24:15];

`ifdef VIGNA_COPROC_RESULT_CACHE_EN
  logic        c_valid_q, c_valid_d;
  logic [2:0]  c_func_q, c_func_d;
  logic [31:0] c_op1_q, c_op1_d;
  logic [31:0] c_op2_q, c_op2_d;
  logic [31:0] c_res_q, c_res_d;

  assign hit     = c_valid_q && (c_func_q == instr[14:12]) &&
                   (c_op1_q == rs1_val) && (c_op2_q == rs2_val);
  assign hit_res = c_res_q;

  // A flush in the same cycle as a capture wins, so the entry ends up invalid.
  always_comb begin
    c_valid_d = c_valid_q;
    c_func_d  = c_func_q;
    c_op1_d   = c_op1_q;
    c_op2_d   = c_op2_q;
    c_res_d   = c_res_q;
    if (cache_flush) begin
      c_valid_d = 1'b0;
    end else if (state_q == S_ISSUE && cp_ready) begin
      c_valid_d = 1'b1;
      c_func_d  = func_q;
      c_op1_d   = op1_q;
      c_op2_d   = op2_q;
      c_res_d   = cp_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      c_valid_q <= 1'b0;
      c_func_q  <= 3'd0;
      c_op1_q   <= 32'd0;
      c_op2_q   <= 32'd0;
      c_res_q   <= 32'd0;
    end else begin
      c_valid_q <= c_valid_d;
      c_func_q  <= c_func_d;
      c_op1_q   <= c_op1_d;
      c_op2_q   <= c_op2_d;
      c_res_q   <= c_res_d;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = cache_flush;
  assign hit          = 1'b0;
  assign hit_res      = 32'd0;
`endif

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    rd_d      = rd_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    res_d     = res_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          func_d = instr[14:12];
          rd_d   = instr[11:7];
          op1_d  = rs1_val;
          op2_d  = rs2_val;
          if (!is_m) begin
            illegal_d = 1'b1;
          end else if (hit) begin
            res_d   = hit_res;
            state_d = (instr[11:7] == 5'd0) ? S_IDLE : S_WB;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Operands stay in op*_q until the next accept, so they are stable for the unit's whole run.
        if (cp_ready) begin
          res_d   = cp_result;
          state_d = (rd_q == 5'd0) ? S_IDLE : S_WB;
        end
      end
      S_WB: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      func_q    <= 3'd0;
      rd_q      <= 5'd0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      res_q     <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      rd_q      <= rd_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
    end
  end

  // Ready is masked by resetn so the core sees the dispatcher busy for the whole reset window.
  assign issue_ready = resetn && (state_q == S_IDLE);
  assign cp_valid    = (state_q == S_ISSUE);
  assign cp_func     = func_q;
  assign cp_id       = 3'b001;
  assign cp_op1      = op1_q;
  assign cp_op2      = op2_q;
  assign wb_valid    = (state_q == S_WB);
  assign wb_rd       = rd_q;
  assign wb_data     = res_q;
  assign illegal     = illegal_q;

endmodule

// File: doc/vigna_coproc_dispatch.md
VIGNA_COPROC_DISPATCH -- requirements
Module: vigna_coproc_dispatch

Interface
REQ-001 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-002 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port issue_valid  input  1  core offers instruction plus operands.
REQ-004 SHALL have port issue_ready  output  1  dispatcher idle; high only in IDLE.
REQ-005 SHALL have port instr  input  32  raw RV32 instruction word.
REQ-006 SHALL have ports rs1_val, rs2_val  input  32 each  source register values.
REQ-007 SHALL have port cp_valid  output  1  request to M-extension unit.
REQ-008 SHALL have port cp_ready  input  1  one-cycle completion pulse from M unit.
REQ-009 SHALL have ports cp_func, cp_id  output  3 each  funct3; unit id, constant 3'b001.
REQ-010 SHALL have ports cp_op1, cp_op2  output  32 each  latched operands.
REQ-011 SHALL have port cp_result  input  32  M unit result, valid when cp_ready=1.
REQ-012 SHALL have ports wb_valid, wb_rd, wb_data  output  1/5/32  register writeback.
REQ-013 SHALL have port wb_ready  input  1  register file accepts writeback.
REQ-014 SHALL have port illegal  output  1  one-cycle pulse: accepted instruction is not M-extension.
REQ-015 SHALL have port cache_flush  input  1  invalidate result cache (REQ-031).

Function
REQ-016 SHALL implement states IDLE, ISSUE, WB.
REQ-017 SHALL accept on issue_valid && issue_ready, latching funct3, rd, rs1_val, rs2_val.
REQ-018 SHALL decode M-ext as instr[6:0]=7'b0110011 && instr[31:25]=7'b0000001.
REQ-019 SHALL, on illegal accept, pulse illegal the next cycle, stay IDLE, never assert cp_valid.
REQ-020 SHALL, on legal accept, enter ISSUE with cp_valid=1 from the next cycle.
REQ-021 SHALL hold cp_func/cp_op1/cp_op2 stable from ISSUE entry until the cycle after cp_ready seen; M unit samples operands throughout its run.
REQ-022 SHALL, at the edge where cp_ready=1 is sampled, clear cp_valid, capture cp_result, and enter WB; cp_valid must be low before M unit returns to idle.
REQ-023 SHALL ignore cp_ready outside ISSUE.
REQ-024 SHALL in WB drive wb_valid=1, wb_rd=rd, wb_data=captured result; return to IDLE on wb_ready.
REQ-025 SHALL, when rd=0, execute but skip WB (IDLE directly; wb_valid never asserted).
REQ-026 SHALL give latency accept->wb_valid = M-unit latency + 2 cycles (uncached).
REQ-027 SHALL not accept new instructions while in ISSUE or WB.

Reset
REQ-028 SHALL on resetn=0 set state IDLE and issue_ready=0 during reset, 1 the cycle after; all other outputs 0.
REQ-029 SHALL abandon any in-flight operation on reset mid-ISSUE/WB; no writeback afterward.
REQ-030 SHALL clear cache valid bit on reset.

Configuration
REQ-031 SHALL, with VIGNA_COPROC_RESULT_CACHE_EN defined, keep one entry {valid, func, op1, op2, result}; a legal accept matching all fields goes IDLE->WB directly (cp_valid never asserted, wb_valid 1 cycle after accept). Entry written on each cp_ready capture; cleared by cache_flush (cache_flush priority over same-cycle write).
REQ-032 SHALL, without the macro, omit cache storage; cache_flush ignored; every legal op goes through ISSUE.

Verification
REQ-033 SHALL cover MUL rs1=7, rs2=6, rd=5 -> one cp_valid request, wb_valid with wb_rd=5, wb_data=42.
REQ-034 SHALL cover DIVU rs1=100, rs2=0 -> wb_data=32'hFFFFFFFF; REM rs1=-7, rs2=2 -> wb_data=32'hFFFFFFFF.
REQ-035 SHALL cover ADD (funct7=0) accept -> illegal pulses once, cp_valid and wb_valid stay 0.
REQ-036 SHALL cover MULHU rd=0 -> cp_valid pulse occurs, no wb_valid, issue_ready back after cp_ready.
REQ-037 SHALL cover resetn low mid-ISSUE of DIV -> all outputs 0, no later wb_valid, next MUL 3*3 returns 9.
REQ-038 SHALL cover (cache enabled) back-to-back identical MUL 5*5 -> second has no cp_valid, wb_data=25 one cycle after accept; after cache_flush, third goes through ISSUE.
